multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
// Parametrised multi-cycle successor to the single-cycle 16-bit RISC datapath. An internal FSM sequences
// FETCH/DECODE/EXEC/MEM/WB, and instruction and data memories sit behind req/ack handshakes, so wait-state
// memories are supported. Houses the PC, IR, an 8-entry register file, the ALU and pipeline latches.
// Decode stays in the external control unit, driven from the opcode output.
// PARAMETERS
// DATA_W    16   register/ALU/data-memory word width (>=8)
// PC_W      16   PC and instruction-address width (>=12)
// RESET_PC  0    PC value loaded on reset
// R0_ZERO   0    1: r0 reads as 0 and writes to it are dropped
// PORTS
// clk         in   1       single clock, all state on posedge
// rst         in   1       synchronous, active-high reset
// jump,beq,bne,mem_read,mem_write,alu_src,reg_dst,mem_to_reg,reg_write  in 1 each  control-unit decode of opcode
// alu_op      in   3       ALU operation
// opcode      out  4       IR[15:12] to control unit
// imem_req    out  1       instruction fetch request
// imem_addr   out  PC_W    fetch address (=PC)
// imem_ack    in   1       fetch complete; imem_rdata valid
// imem_rdata  in   16      instruction word
// dmem_req    out  1       data access request
// dmem_we     out  1       1=store, 0=load
// dmem_addr   out  DATA_W  ALU result
// dmem_wdata  out  DATA_W  rs2 value
// dmem_ack    in   1       access complete; dmem_rdata valid on loads
// dmem_rdata  in   DATA_W  load data
// pc_out      out  PC_W    current PC (debug)
// retire      out  1       1-cycle pulse when an instruction completes
// BEHAVIOUR
// - Reset (sync, rst high at posedge): state=FETCH, PC=RESET_PC, IR=0, regs=0, latches=0. All outputs 0 during rst
//   except pc_out=RESET_PC. Reset mid-handshake drops req next cycle; a late ack is ignored.
// - Instruction fields: rs1=IR[11:9], rs2=IR[8:6], rd=reg_dst?IR[5:3]:IR[8:6], imm6=IR[5:0] sign-extended to DATA_W.
// - FETCH: imem_req=1, imem_addr=PC held stable until ack. On ack edge: IR<=imem_rdata, go to DECODE.
//   Zero-wait (ack in the same cycle as req) gives a one-cycle FETCH.
// - DECODE: opcode valid. Capture A<=R[rs1] and B<=R[rs2]. Capture all control inputs into registers; they are
//   ignored after this cycle. Go to EXEC.
// - EXEC: ALU computes on A and (alu_src?imm:B), mod 2^DATA_W.
//   alu_op: 000 add, 001 sub, 010 ~a, 011 a<<b[3:0], 100 a>>b[3:0], 101 and, 110 or, 111 slt (signed, 1/0).
//   Latch ALUOUT; zero=(result==0).
//   - jump: PC<={PC+1[PC_W-1:12],IR[11:0]}; retire; go to FETCH. Jump has priority over branch.
//   - beq&zero | bne&~zero: PC<=PC+1+sext(imm6), wraps mod 2^PC_W.
//   - Otherwise PC<=PC+1, wraps.
//   - Next state: mem_write|mem_read -> MEM. Otherwise reg_write -> WB. Otherwise retire and go to FETCH.
// - MEM: dmem_req=1; dmem_we=mem_write; addr=ALUOUT and wdata=B held until ack. If mem_write and mem_read are
//   both set, treat as a store. On ack: store -> retire and go to FETCH (reg_write ignored); load -> MDR<=rdata,
//   go to WB.
// - WB: R[rd]<=mem_to_reg?MDR:ALUOUT. If R0_ZERO=1 and rd=0, the write is dropped. Retire; go to FETCH.
// - PC updates in EXEC, so a stalled MEM never re-fetches. pc_out equals the PC presented in FETCH.
// - Latency at zero wait: ALU op 4 cycles, load 5, store 4, branch/jump 3. Each wait cycle adds 1.
// - At most one of imem_req and dmem_req is high in any cycle.
// TESTING
// 1 Reset: rst high for 2 cycles mid-FETCH with imem_ack=0 -> imem_req=0 and pc_out=0 during rst;
//   req rises the cycle after rst falls.
// 2 ALU/latency: R1=5, R2=3, add r3=r1+r2 with zero-wait memories -> R3=8 after 4 cycles, retire pulses once;
//   sub 3-5 -> 16'hFFFE.
// 3 Wait states: imem_ack delayed 3 cycles, dmem_ack delayed 2 on a load -> imem_addr and dmem_addr stable
//   throughout; load completes in 10 cycles with the correct value.
// 4 Branch: PC=16'h0010, beq taken, imm6=6'h3E (-2) -> PC=16'h000F; bne with zero=1 -> PC=16'h0011;
//   PC=16'hFFFF, not-taken -> PC=0.
// 5 Jump priority: jump=1 and beq=1 both set, PC=16'h1234, IR[11:0]=12'h0AB -> PC=16'h10AB.
// 6 Params: DATA_W=32, R0_ZERO=1 -> write to r0 dropped (reads 0); add 32'hFFFFFFFF+1 wraps to 0 with zero=1.

Source files
------------

// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//   Multi-cycle 16-bit RISC datapath. An internal FSM walks every instruction
//   through FETCH / DECODE / EXEC / MEM / WB. Instruction and data memories sit
//   behind req/ack handshakes, so memories with wait states are supported.
//   Opcode decode lives in an external control unit. That unit sees the opcode
//   output, and its decode is captured once during DECODE.
//
// Parameters
//   DATA_W    register / ALU / data-memory word width (>= 8)
//   PC_W      PC and instruction-address width (>= 12)
//   RESET_PC  PC value loaded by reset
//   R0_ZERO   1: r0 always reads as zero and writes to it are dropped
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   jump..reg_write, alu_op       control-unit decode of the current opcode
//   opcode                        IR[15:12] to the control unit
//   imem_req/addr/ack/rdata       instruction fetch handshake
//   dmem_req/we/addr/wdata/ack/rdata  data access handshake
//   pc_out                        current PC
//   retire                        one-cycle pulse per completed instruction
// -----------------------------------------------------------------------------
module multicycle_datapath #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [2:0]        alu_op,
    output logic [3:0]        opcode,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc_out,
    output logic              retire
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1'b1);
    localparam logic [PC_W-1:0] JMP_MASK = PC_W'(12'hFFF);

    state_t              state_r, state_next;
    logic [PC_W-1:0]     pc_r, pc_next;
    logic [15:0]         ir_r;
    logic [DATA_W-1:0]   a_r, b_r, aluout_r, mdr_r;
    logic [DATA_W-1:0]   regs_r [8];

    // Control decode captured during DECODE
    logic                jump_r, beq_r, bne_r, mem_read_r, mem_write_r;
    logic                alu_src_r, reg_dst_r, mem_to_reg_r, reg_write_r;
    logic [2:0]          alu_op_r;

    // Registered outputs
    logic                imem_req_r, dmem_req_r, dmem_we_r, retire_r;
    logic [PC_W-1:0]     imem_addr_r;

    // Instruction fields and datapath nets
    logic [2:0]          rs1_s, rs2_s, rd_s;
    logic [DATA_W-1:0]   imm_s, rd1_s, rd2_s, operand_b_s, alu_res_s, wb_data_s;
    logic                zero_s, retire_s, rf_we_s;
    logic [PC_W-1:0]     pc_inc_s, br_tgt_s, jump_tgt_s, ir_low_s, pc_imm_s;

    assign rs1_s      = ir_r[11:9];
    assign rs2_s      = ir_r[8:6];
    assign rd_s       = reg_dst_r ? ir_r[5:3] : ir_r[8:6];
    assign imm_s      = {{(DATA_W-6){ir_r[5]}}, ir_r[5:0]};
    assign pc_imm_s   = {{(PC_W-6){ir_r[5]}}, ir_r[5:0]};
    assign ir_low_s   = PC_W'(ir_r[11:0]);
    assign pc_inc_s   = pc_r + PC_ONE;
    assign br_tgt_s   = pc_inc_s + pc_imm_s;
    // Jump keeps the upper bits of PC+1 and replaces the low 12 bits
    assign jump_tgt_s = (pc_inc_s & ~JMP_MASK) | ir_low_s;

    // With R0_ZERO the r0 read port is forced to zero
    assign rd1_s = ((R0_ZERO != 0) && (rs1_s == 3'd0)) ? '0 : regs_r[rs1_s];
    assign rd2_s = ((R0_ZERO != 0) && (rs2_s == 3'd0)) ? '0 : regs_r[rs2_s];

    assign operand_b_s = alu_src_r ? imm_s : b_r;
    assign wb_data_s   = mem_to_reg_r ? mdr_r : aluout_r;
    assign rf_we_s     = (state_r == S_WB) && !((R0_ZERO != 0) && (rd_s == 3'd0));

    // ALU: result wraps modulo 2^DATA_W
    always_comb begin
        alu_res_s = '0;
        case (alu_op_r)
            3'b000:  alu_res_s = a_r + operand_b_s;
            3'b001:  alu_res_s = a_r - operand_b_s;
            3'b010:  alu_res_s = ~a_r;
            3'b011:  alu_res_s = a_r << operand_b_s[3:0];
            3'b100:  alu_res_s = a_r >> operand_b_s[3:0];
            3'b101:  alu_res_s = a_r & operand_b_s;
            3'b110:  alu_res_s = a_r | operand_b_s;
            3'b111:  alu_res_s = ($signed(a_r) < $signed(operand_b_s)) ? DATA_W'(1'b1) : '0;
            default: alu_res_s = '0;
        endcase
        zero_s = (alu_res_s == '0);
    end

    // Next-state, next-PC and retire decode
    always_comb begin
        state_next = state_r;
        pc_next    = pc_r;
        retire_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                // An ack only counts while our request is actually up
                if (imem_req_r && imem_ack) begin
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (jump_r) begin
                    pc_next = jump_tgt_s;
                end else if ((beq_r && zero_s) || (bne_r && !zero_s)) begin
                    pc_next = br_tgt_s;
                end else begin
                    pc_next = pc_inc_s;
                end
                if (jump_r) begin
                    state_next = S_FETCH;
                    retire_s   = 1'b1;
                end else if (mem_write_r || mem_read_r) begin
                    state_next = S_MEM;
                end else if (reg_write_r) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_FETCH;
                    retire_s   = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_req_r && dmem_ack) begin
                    // Store wins when both mem_read and mem_write are set
                    if (mem_write_r) begin
                        state_next = S_FETCH;
                        retire_s   = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    state_next = S_MEM;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire_s   = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State, PC, IR, pipeline latches and captured control decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_FETCH;
            pc_r         <= PC_RST;
            ir_r         <= 16'h0000;
            a_r          <= '0;
            b_r          <= '0;
            aluout_r     <= '0;
            mdr_r        <= '0;
            jump_r       <= 1'b0;
            beq_r        <= 1'b0;
            bne_r        <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            reg_dst_r    <= 1'b0;
            mem_to_reg_r <= 1'b0;
            reg_write_r  <= 1'b0;
            alu_op_r     <= 3'b000;
        end else begin
            state_r <= state_next;
            pc_r    <= pc_next;
            if ((state_r == S_FETCH) && imem_req_r && imem_ack) begin
                ir_r <= imem_rdata;
            end
            if (state_r == S_DECODE) begin
                a_r          <= rd1_s;
                b_r          <= rd2_s;
                jump_r       <= jump;
                beq_r        <= beq;
                bne_r        <= bne;
                mem_read_r   <= mem_read;
                mem_write_r  <= mem_write;
                alu_src_r    <= alu_src;
                reg_dst_r    <= reg_dst;
                mem_to_reg_r <= mem_to_reg;
                reg_write_r  <= reg_write;
                alu_op_r     <= alu_op;
            end
            if (state_r == S_EXEC) begin
                aluout_r <= alu_res_s;
            end
            if ((state_r == S_MEM) && dmem_req_r && dmem_ack && !mem_write_r) begin
                mdr_r <= dmem_rdata;
            end
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= '0;
            end
        end else if (rf_we_s) begin
            regs_r[rd_s] <= wb_data_s;
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req_r  <= 1'b0;
            dmem_req_r  <= 1'b0;
            dmem_we_r   <= 1'b0;
            retire_r    <= 1'b0;
            imem_addr_r <= '0;
        end else begin
            imem_req_r  <= (state_next == S_FETCH);
            dmem_req_r  <= (state_next == S_MEM);
            dmem_we_r   <= (state_next == S_MEM) && mem_write_r;
            retire_r    <= retire_s;
            imem_addr_r <= pc_next;
        end
    end

    assign opcode     = ir_r[15:12];
    assign imem_req   = imem_req_r;
    assign imem_addr  = imem_addr_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = aluout_r;
    assign dmem_wdata = b_r;
    assign pc_out     = pc_r;
    assign retire     = retire_r;

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//   Directed bench. Two instances share every input and run in lock-step:
//   u_a uses the default parameters, and u_b uses DATA_W=32, R0_ZERO=1 and
//   RESET_PC=16'hFFFF. The bench plays both the control unit and the
//   memories. Register contents are observed through stores: dmem_wdata
//   carries rs2 and dmem_addr carries the ALU result.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [2:0]  alu_op;
    logic        imem_ack, dmem_ack;
    logic [15:0] imem_rdata;
    logic [31:0] dmem_rdata;

    logic [3:0]  a_opcode, b_opcode;
    logic        a_imem_req, b_imem_req, a_dmem_req, b_dmem_req, a_dmem_we, b_dmem_we;
    logic        a_retire, b_retire;
    logic [15:0] a_imem_addr, b_imem_addr, a_pc_out, b_pc_out;
    logic [15:0] a_dmem_addr, a_dmem_wdata;
    logic [31:0] b_dmem_addr, b_dmem_wdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cap_a_addr, cap_a_wd, cap_b_addr, cap_b_wd;

    // control vector order: {jump,beq,bne,mem_read,mem_write,alu_src,reg_dst,mem_to_reg,reg_write}
    localparam logic [8:0] C_ADDI = 9'h009;
    localparam logic [8:0] C_RR   = 9'h005;
    localparam logic [8:0] C_SW   = 9'h018;
    localparam logic [8:0] C_LW   = 9'h02B;
    localparam logic [8:0] C_BEQ  = 9'h080;
    localparam logic [8:0] C_BNE  = 9'h040;
    localparam logic [8:0] C_J    = 9'h100;
    localparam logic [8:0] C_JBEQ = 9'h188;
    localparam logic [8:0] C_SWBQ = 9'h098;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b101;

    always #5 clk = ~clk;

    multicycle_datapath u_a (
        .clk(clk), .rst(rst), .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_op(alu_op), .opcode(a_opcode), .imem_req(a_imem_req),
        .imem_addr(a_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr),
        .dmem_wdata(a_dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata[15:0]),
        .pc_out(a_pc_out), .retire(a_retire)
    );

    multicycle_datapath #(.DATA_W(32), .PC_W(16), .RESET_PC(32'h0000FFFF), .R0_ZERO(1)) u_b (
        .clk(clk), .rst(rst), .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_op(alu_op), .opcode(b_opcode), .imem_req(b_imem_req),
        .imem_addr(b_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr),
        .dmem_wdata(b_dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(b_pc_out), .retire(b_retire)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic [5:0] lo);
        return {op, s1, s2, lo};
    endfunction

    // Runs one instruction, starting at a negedge where the fetch request is up.
    // Acks are given after the requested number of wait cycles. The task returns
    // at the negedge where retire is seen, and checks the cycle count.
    task automatic run_instr(input string name, input logic [15:0] instr, input logic [8:0] ctl,
                             input logic [2:0] op, input int iwait, input int dwait,
                             input logic [31:0] ldata, input int exp_lat);
        int          k;
        int          iw;
        int          dw;
        bit          done;
        logic [15:0] iaddr0;
        logic [31:0] daddr0;
        {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = ctl;
        alu_op = op;
        k = 0; iw = 0; dw = 0; done = 1'b0; iaddr0 = '0; daddr0 = '0;
        while (!done && k < 40) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            check_eq({name, "_one_req"}, {31'd0, a_imem_req & a_dmem_req}, 32'd0);
            if (a_imem_req) begin
                if (iw == 0) iaddr0 = a_imem_addr;
                else check_eq({name, "_imem_addr_stable"}, {16'd0, a_imem_addr}, {16'd0, iaddr0});
                if (iw == iwait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instr;
                end else begin
                    imem_rdata = 16'hDEAD;
                end
                iw++;
            end
            if (a_dmem_req) begin
                if (dw == 0) daddr0 = {16'd0, a_dmem_addr};
                else check_eq({name, "_dmem_addr_stable"}, {16'd0, a_dmem_addr}, daddr0);
                if (dw == dwait) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = ldata;
                    cap_a_addr = {16'd0, a_dmem_addr};
                    cap_a_wd   = {16'd0, a_dmem_wdata};
                    cap_b_addr = b_dmem_addr;
                    cap_b_wd   = b_dmem_wdata;
                    check_eq({name, "_dmem_we"}, {31'd0, a_dmem_we}, {31'd0, ctl[4]});
                end else begin
                    dmem_rdata = 32'hBAD0BAD0;
                end
                dw++;
            end
            @(negedge clk);
            k++;
            if (a_retire) done = 1'b1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!done) check_eq({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            check_eq({name, "_latency"}, k, exp_lat);
            check_eq({name, "_b_retire"}, {31'd0, b_retire}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = 9'h000;
        alu_op = 3'b000; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0000; dmem_rdata = 32'h0;
        cap_a_addr = '0; cap_a_wd = '0; cap_b_addr = '0; cap_b_wd = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_imem_req", {31'd0, a_imem_req}, 32'd0);
        check_eq("rst_dmem_req", {31'd0, a_dmem_req}, 32'd0);
        check_eq("rst_retire",   {31'd0, a_retire}, 32'd0);
        check_eq("rst_opcode",   {28'd0, a_opcode}, 32'd0);
        check_eq("rst_pc_a",     {16'd0, a_pc_out}, 32'h0000);
        check_eq("rst_pc_b",     {16'd0, b_pc_out}, 32'hFFFF);

        // Reset asserted in the middle of an unacknowledged fetch
        rst = 1'b0;
        @(negedge clk);
        check_eq("fetch_req_up", {31'd0, a_imem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_imem_req", {31'd0, a_imem_req}, 32'd0);
            check_eq("midrst_pc",       {16'd0, a_pc_out}, 32'd0);
        end
        rst = 1'b0;
        imem_ack = 1'b1;          // late ack while no request is up: must be ignored
        imem_rdata = 16'hF000;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("req_after_rst",   {31'd0, a_imem_req}, 32'd1);
        check_eq("late_ack_ignored", {28'd0, a_opcode}, 32'd0);

        // ALU and latency
        run_instr("addi_r1", enc(4'h1, 3'd0, 3'd1, 6'd5), C_ADDI, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("pc_a_1", {16'd0, a_pc_out}, 32'h0001);
        check_eq("pc_b_wrap", {16'd0, b_pc_out}, 32'h0000);
        run_instr("addi_r2", enc(4'h1, 3'd0, 3'd2, 6'd3), C_ADDI, OP_ADD, 0, 0, 32'd0, 4);
        run_instr("add_r3", enc(4'h2, 3'd1, 3'd2, 6'o30), C_RR, OP_ADD, 0, 0, 32'd0, 4);
        run_instr("sw_r3", enc(4'h3, 3'd0, 3'd3, 6'd0), C_SW, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("r3_a", cap_a_wd, 32'h0008);
        check_eq("r3_b", cap_b_wd, 32'h0000_0008);
        run_instr("sub_r4", enc(4'h2, 3'd2, 3'd1, 6'o40), C_RR, OP_SUB, 0, 0, 32'd0, 4);
        run_instr("sw_r4", enc(4'h3, 3'd0, 3'd4, 6'd0), C_SW, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("r4_a", cap_a_wd, 32'h0000_FFFE);
        check_eq("r4_b", cap_b_wd, 32'hFFFF_FFFE);

        // Load through wait-state memories
        run_instr("lw_wait", enc(4'h4, 3'd1, 3'd5, 6'd2), C_LW, OP_ADD, 3, 2, 32'h0000_A5C3, 10);
        check_eq("lw_addr", cap_a_addr, 32'h0007);
        check_eq("lw_opcode", {28'd0, a_opcode}, 32'h4);
        run_instr("sw_r5", enc(4'h3, 3'd0, 3'd5, 6'd0), C_SW, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("r5_a", cap_a_wd, 32'h0000_A5C3);
        check_eq("pc_a_8", {16'd0, a_pc_out}, 32'h0008);

        // Branches
        run_instr("j_010", {4'h5, 12'h010}, C_J, OP_ADD, 0, 0, 32'd0, 3);
        check_eq("pc_j_010", {16'd0, a_pc_out}, 32'h0010);
        run_instr("beq_taken", {4'h6, 3'd1, 3'd1, 6'h3E}, C_BEQ, OP_SUB, 0, 0, 32'd0, 3);
        check_eq("pc_beq_taken", {16'd0, a_pc_out}, 32'h000F);
        run_instr("j_010b", {4'h5, 12'h010}, C_J, OP_ADD, 0, 0, 32'd0, 3);
        run_instr("bne_zero", {4'h7, 3'd1, 3'd1, 6'h3E}, C_BNE, OP_SUB, 0, 0, 32'd0, 3);
        check_eq("pc_bne_not_taken", {16'd0, a_pc_out}, 32'h0011);
        run_instr("bne_taken", {4'h7, 3'd1, 3'd2, 6'h3E}, C_BNE, OP_SUB, 0, 0, 32'd0, 3);
        check_eq("pc_bne_taken", {16'd0, a_pc_out}, 32'h0010);

        // Jump priority at PC=16'h1234
        run_instr("j_fff", {4'h5, 12'hFFF}, C_J, OP_ADD, 0, 0, 32'd0, 3);
        check_eq("pc_j_fff", {16'd0, a_pc_out}, 32'h0FFF);
        run_instr("j_234", {4'h5, 12'h234}, C_J, OP_ADD, 0, 0, 32'd0, 3);
        check_eq("pc_j_1234", {16'd0, a_pc_out}, 32'h1234);
        run_instr("j_beq", {4'h8, 12'h0AB}, C_JBEQ, OP_AND, 0, 0, 32'd0, 3);
        check_eq("pc_jump_priority", {16'd0, a_pc_out}, 32'h10AB);
        check_eq("pc_b_jump_priority", {16'd0, b_pc_out}, 32'h10AB);

        // r0 handling and 32-bit wrap
        run_instr("addi_r0", enc(4'h1, 3'd0, 3'd0, 6'd5), C_ADDI, OP_ADD, 0, 0, 32'd0, 4);
        run_instr("sw_r0", enc(4'h3, 3'd0, 3'd0, 6'd0), C_SW, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("r0_a_written", cap_a_wd, 32'h0005);
        check_eq("r0_b_dropped", cap_b_wd, 32'h0);
        check_eq("r0_b_addr", cap_b_addr, 32'h0);
        run_instr("addi_r6", enc(4'h1, 3'd0, 3'd6, 6'h3F), C_ADDI, OP_ADD, 0, 0, 32'd0, 4);
        run_instr("sw_r6", enc(4'h3, 3'd0, 3'd6, 6'd0), C_SW, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("r6_b", cap_b_wd, 32'hFFFF_FFFF);
        check_eq("r6_a", cap_a_wd, 32'h0004);
        run_instr("sw_beq_wrap", {4'h9, 3'd6, 3'd0, 6'd1}, C_SWBQ, OP_ADD, 0, 0, 32'd0, 4);
        check_eq("wrap_b_addr", cap_b_addr, 32'h0);
        check_eq("wrap_a_addr", cap_a_addr, 32'h0005);
        check_eq("wrap_b_zero_pc", {16'd0, b_pc_out}, 32'h10B1);
        check_eq("wrap_a_pc", {16'd0, a_pc_out}, 32'h10B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
